// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and line-refill signals of the direct-mapped instruction cache
interface icache_dm_if #(parameter int LINE = 256);
  logic icache_read_i;
  logic [31:0] icache_addr_i;
  logic [31:0] icache_rdata_o;
  logic icache_resp_o;
  logic pmem_read_o;
  logic [31:0] pmem_address_o;
  logic [LINE-1:0] pmem_rdata_i;
  logic pmem_resp_i;
  logic [31:0] icache_miss_count_o;
  modport master(
    output icache_read_i, icache_addr_i, pmem_rdata_i, pmem_resp_i,
    input icache_rdata_o, icache_resp_o, pmem_read_o, pmem_address_o, icache_miss_count_o
  );
  modport slave(
    input icache_read_i, icache_addr_i, pmem_rdata_i, pmem_resp_i,
    output icache_rdata_o, icache_resp_o, pmem_read_o, pmem_address_o, icache_miss_count_o
  );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: read-only direct-mapped instruction cache with whole-line refill
module icache_dm #(
  parameter int S_INDEX = 3,
  parameter int S_OFFSET = 5,
  parameter int S_TAG = 32 - S_INDEX - S_OFFSET
) (
  input logic clk,
  input logic rst,
  icache_dm_if.slave bus
);
  localparam int SETS = 1 << S_INDEX;
  localparam int LINE = 8 << S_OFFSET;
  typedef enum logic {CHECK, FETCH} state_t;
  state_t state, state_nx;
  logic [SETS-1:0] valid;
  logic [S_TAG-1:0] tags [SETS];
  logic [LINE-1:0] data [SETS];
  logic [S_TAG-1:0] tag, lat_tag;
  logic [S_INDEX-1:0] idx, lat_idx;
  logic [S_OFFSET-3:0] word;
  logic hit, miss, fill;
  logic unused_ok;
  assign tag = bus.icache_addr_i[31-:S_TAG];
  assign idx = bus.icache_addr_i[S_OFFSET+:S_INDEX];
  assign word = bus.icache_addr_i[2+:S_OFFSET-2];
  assign unused_ok = ^bus.icache_addr_i[1:0];
  assign hit = valid[idx] && tags[idx] == tag;
  assign miss = state == CHECK && bus.icache_read_i && !hit;
  assign fill = state == FETCH && bus.pmem_resp_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= CHECK;
    else state <= state_nx;
  // Responses only ever come from CHECK, so a hit that appears mid-refill waits its turn
  always_comb begin
    state_nx = state == CHECK ? (miss ? FETCH : CHECK) : (bus.pmem_resp_i ? CHECK : FETCH);
    bus.icache_resp_o = state == CHECK && bus.icache_read_i && hit;
    bus.icache_rdata_o = bus.icache_resp_o ? data[idx][{word, 5'd0}+:32] : '0;
    bus.pmem_read_o = state == FETCH;
    bus.pmem_address_o = state == FETCH ? {lat_tag, lat_idx, {S_OFFSET{1'b0}}} : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= '0;
      lat_tag <= '0;
      lat_idx <= '0;
      bus.icache_miss_count_o <= '0;
    end else begin
      if (miss) {lat_tag, lat_idx} <= {tag, idx};
      if (fill) valid[lat_idx] <= 1'b1;
      if (fill && bus.icache_miss_count_o != '1) bus.icache_miss_count_o <= bus.icache_miss_count_o + 32'd1;
    end
  always_ff @(posedge clk)
    if (fill) begin
      tags[lat_idx] <= lat_tag;
      data[lat_idx] <= bus.pmem_rdata_i;
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed checks of hits, refills, eviction, mid-refill address change and reset
module tb_icache_dm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  localparam logic [31:0] WA = 32'hA000_0000;
  localparam logic [31:0] WB = 32'hB000_0000;
  localparam logic [31:0] WC = 32'hC000_0000;
  localparam logic [31:0] WD = 32'hD000_0000;
  icache_dm_if bus();
  icache_dm dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [255:0] line(input logic [31:0] b);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k+:32] = b + k;
    return l;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic look(input string tag, input logic resp, input logic [31:0] rdata, input logic pread, input logic [31:0] paddr);
    chk({tag, ".resp"}, {31'd0, bus.icache_resp_o}, {31'd0, resp});
    chk({tag, ".rdata"}, bus.icache_rdata_o, rdata);
    chk({tag, ".pread"}, {31'd0, bus.pmem_read_o}, {31'd0, pread});
    chk({tag, ".paddr"}, bus.pmem_address_o, paddr);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  initial begin
    bus.icache_read_i = 1'b0;
    bus.icache_addr_i = '0;
    bus.pmem_rdata_i = '0;
    bus.pmem_resp_i = 1'b0;
    #2 look("rst0", 1'b0, 0, 1'b0, 0);
    chk("rst0.cnt", bus.icache_miss_count_o, 0);
    tick(); tick(); rst = 1'b1;
    bus.icache_read_i = 1'b1; bus.icache_addr_i = 32'h0;
    mid(); look("t1_miss", 1'b0, 0, 1'b0, 0);
    tick(); mid(); look("t1_fetch", 1'b0, 0, 1'b1, 0);
    tick(); #2 rst = 1'b0;
    #1 look("t1_async_rst", 1'b0, 0, 1'b0, 0);
    chk("t1_async_rst.cnt", bus.icache_miss_count_o, 0);
    bus.icache_read_i = 1'b0;
    tick(); rst = 1'b1;
    bus.pmem_resp_i = 1'b1; bus.pmem_rdata_i = line(WD);
    mid(); look("t6_stray", 1'b0, 0, 1'b0, 0);
    tick(); bus.pmem_resp_i = 1'b0; bus.icache_read_i = 1'b1; bus.icache_addr_i = 32'h0;
    mid(); look("t6_nowrite", 1'b0, 0, 1'b0, 0);
    chk("t6_nowrite.cnt", bus.icache_miss_count_o, 0);
    tick(); mid(); look("t6_fetch", 1'b0, 0, 1'b1, 0);
    #1 rst = 1'b0;
    #1 look("t6_rst_fetch", 1'b0, 0, 1'b0, 0);
    bus.icache_read_i = 1'b0;
    tick(); rst = 1'b1;
    bus.icache_read_i = 1'b1; bus.icache_addr_i = 32'h64;
    mid(); look("t2_c1", 1'b0, 0, 1'b0, 0);
    tick(); mid(); look("t2_c2", 1'b0, 0, 1'b1, 32'h60);
    tick(); mid(); look("t2_c3", 1'b0, 0, 1'b1, 32'h60);
    tick(); bus.pmem_resp_i = 1'b1; bus.pmem_rdata_i = line(WA);
    mid(); look("t2_c4", 1'b0, 0, 1'b1, 32'h60);
    tick(); bus.pmem_resp_i = 1'b0;
    mid(); look("t2_c5", 1'b1, WA + 1, 1'b0, 0);
    chk("t2.cnt", bus.icache_miss_count_o, 1);
    tick(); bus.icache_addr_i = 32'h60;
    mid(); look("t3_60", 1'b1, WA + 0, 1'b0, 0);
    tick(); bus.icache_addr_i = 32'h68;
    mid(); look("t3_68", 1'b1, WA + 2, 1'b0, 0);
    tick(); bus.icache_addr_i = 32'h7C;
    mid(); look("t3_7c", 1'b1, WA + 7, 1'b0, 0);
    chk("t3.cnt", bus.icache_miss_count_o, 1);
    tick(); bus.icache_addr_i = 32'h164;
    mid(); look("t4_miss", 1'b0, 0, 1'b0, 0);
    tick(); mid(); look("t4_f1", 1'b0, 0, 1'b1, 32'h160);
    tick(); bus.pmem_resp_i = 1'b1; bus.pmem_rdata_i = line(WB);
    mid(); look("t4_f2", 1'b0, 0, 1'b1, 32'h160);
    tick(); bus.pmem_resp_i = 1'b0;
    mid(); look("t4_hit", 1'b1, WB + 1, 1'b0, 0);
    chk("t4_hit.cnt", bus.icache_miss_count_o, 2);
    tick(); bus.icache_addr_i = 32'h64;
    mid(); look("t4_evicted", 1'b0, 0, 1'b0, 0);
    tick(); bus.pmem_resp_i = 1'b1; bus.pmem_rdata_i = line(WA);
    mid(); look("t4_refetch", 1'b0, 0, 1'b1, 32'h60);
    tick(); bus.pmem_resp_i = 1'b0;
    mid(); look("t4_rehit", 1'b1, WA + 1, 1'b0, 0);
    chk("t4.cnt", bus.icache_miss_count_o, 3);
    tick(); bus.icache_addr_i = 32'h200;
    mid(); look("t5_miss", 1'b0, 0, 1'b0, 0);
    tick(); mid(); look("t5_f1", 1'b0, 0, 1'b1, 32'h200);
    tick(); bus.icache_addr_i = 32'h64;
    mid(); look("t5_f2", 1'b0, 0, 1'b1, 32'h200);
    tick(); bus.pmem_resp_i = 1'b1; bus.pmem_rdata_i = line(WC);
    mid(); look("t5_f3", 1'b0, 0, 1'b1, 32'h200);
    tick(); bus.pmem_resp_i = 1'b0;
    mid(); look("t5_after", 1'b1, WA + 1, 1'b0, 0);
    chk("t5.cnt", bus.icache_miss_count_o, 4);
    tick(); bus.icache_addr_i = 32'h200;
    mid(); look("t5_new", 1'b1, WC + 0, 1'b0, 0);
    tick(); bus.icache_read_i = 1'b0;
    mid(); look("idle", 1'b0, 0, 1'b0, 0);
    chk("idle.cnt", bus.icache_miss_count_o, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
